approx_mult_err_accum: RTL and testbench
========================================

// Module: approx_mult_err_accum
// PURPOSE
//  Downstream error-metric stage for the approximate multiplier (N-bit A,B -> 2N-bit PRODUCT).
//  Takes each operand pair plus the approximate product and recomputes the exact product.
//  Accumulates error distance (ED), max ED and erroneous-sample count over a fixed-length run.
//  Lets silicon/FPGA builds report accuracy metrics without dumping every product.
// PARAMETERS
//  N           16   operand width; product width is 2N
//  NUM_SAMPLES 256  samples per run (1..65535)
//  ACC_W       48   ED-sum width; >= 2N+clog2(NUM_SAMPLES), so it cannot overflow
// PORTS
//  clk            in   1     rising-edge clock
//  rst_n          in   1     async active-low reset
//  start          in   1     begin run (honoured in IDLE/DONE only)
//  in_valid       in   1     a/b/approx_product valid this cycle
//  in_ready       out  1     1 while in RUN and sample_cnt<NUM_SAMPLES
//  a, b           in   N     operands fed to the multiplier
//  approx_product in   2N    multiplier PRODUCT for a,b
//  busy           out  1     state != IDLE && state != DONE
//  done           out  1     level; high in DONE
//  sample_cnt     out  16    samples accepted this run
//  err_cnt        out  16    samples with ED != 0
//  max_ed         out  2N    largest ED this run
//  sum_ed         out  ACC_W sum of ED this run
//  sum_sq_ed      out  ACC_W+2N  sum of ED^2 (only with ERR_SQ_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; every output and internal register 0; in_ready=0.
//  - FSM: IDLE -start-> RUN; RUN -(sample_cnt==NUM_SAMPLES)-> DRAIN;
//    DRAIN -(pipeline empty)-> DONE; DONE -start-> RUN.
//  - start in RUN/DRAIN is ignored. start entering RUN clears counters/accumulators same edge.
//  - Accept = in_valid && in_ready. in_valid while in_ready=0 is dropped, no side effect.
//  - Pipe stage 1 (accept edge): register a*b (exact, 2N unsigned) and approx_product;
//    sample_cnt++. Stage 2 (next edge): ED=|exact-approx| (unsigned 2N, either sign of diff);
//    sum_ed+=ED; err_cnt+= (ED!=0); max_ed=max(max_ed,ED).
//  - Latency: a sample is in sum_ed/err_cnt/max_ed 2 edges after accept. DRAIN lasts 2 cycles.
//  - Accepting back-to-back every cycle is supported; no stalls.
//  - in_ready falls the cycle after the NUM_SAMPLES-th accept (combinational from count/state).
//  - Results hold stable in DONE until next start. done deasserts the edge start is taken.
//  - Reset mid-run: immediate return to IDLE, all results lost.
//  - Counters never wrap: NUM_SAMPLES<=65535 bounds sample_cnt/err_cnt.
// CONFIGURATION
//  ERR_SQ_EN defined: extra stage-2 multiplier; sum_sq_ed+=ED*ED (width ACC_W+2N),
//    cleared/held like sum_ed; enables MSE = sum_sq_ed/NUM_SAMPLES offline. Latency unchanged.
//  ERR_SQ_EN undefined: port sum_sq_ed absent; no squaring logic synthesised.
// TESTING (N=16, NUM_SAMPLES=4 unless stated)
//  1. Reset mid-run after 2 accepts -> all outputs 0, state IDLE, in_ready=0.
//  2. 4 samples with approx=a*b exactly (a=FFFF,b=FFFF etc.) -> done=1, err_cnt=0, sum_ed=0,
//     max_ed=0, sample_cnt=4.
//  3. a=FFFF,b=8888 approx=0x8887_7778-0x10; a=FFFF,b=89FF approx exact+5 -> ED 16 and 5;
//     plus 2 exact samples -> err_cnt=2, sum_ed=21, max_ed=16; ERR_SQ_EN: sum_sq_ed=281.
//  4. in_valid held high 6 cycles from RUN entry -> exactly 4 accepted; in_ready low from
//     cycle 5; done 3 cycles after last accept.
//  5. start pulsed in RUN and in DRAIN -> ignored; start in DONE -> counters cleared, new run
//     results independent of previous.
//  6. NUM_SAMPLES=65535, every approx=0 with a=b=FFFF -> err_cnt=65535,
//     max_ed=0xFFFE0001, sum_ed=65535*0xFFFE0001 with no overflow.

Source files
------------

// File: rtl/approx_mult_err_accum_if.sv
// Operand/product bus between the approximate multiplier (or its source)
// and the error-metric accumulator.
//   in_valid        : a/b/approx_product valid this cycle (master -> slave)
//   in_ready        : accumulator can take a sample this cycle (slave -> master)
//   a, b            : N-bit unsigned operands fed to the multiplier
//   approx_product  : 2N-bit approximate product of a and b
interface approx_mult_err_accum_if #(
  parameter int N = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [2*N-1:0]   approx_product;

  modport master (
    output in_valid,
    output a,
    output b,
    output approx_product,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  approx_product,
    output in_ready
  );
endinterface

// File: rtl/approx_mult_err_accum.sv
// Error-metric stage for an approximate multiplier. Each accepted sample
// (a, b, approx_product) has its exact product recomputed; the absolute error
// distance ED = |a*b - approx_product| is folded into a run of NUM_SAMPLES:
// sum of ED, max ED and count of samples with ED != 0.
//
// Optional feature macro: ERR_SQ_EN -- adds a stage-2 squarer and the
// sum_sq_ed output (sum of ED^2). Without it the port and logic are absent.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a run (taken only in IDLE or DONE)
//   bus          : slave side of approx_mult_err_accum_if (in_valid/in_ready,
//                  a, b, approx_product)
//   busy         : run or drain in progress
//   done         : level, high while results are held in DONE
//   sample_cnt   : samples accepted this run
//   err_cnt      : samples with ED != 0
//   max_ed       : largest ED this run
//   sum_ed       : sum of ED this run
//   sum_sq_ed    : sum of ED^2 this run (ERR_SQ_EN only)
module approx_mult_err_accum #(
  parameter int N           = 16,
  parameter int NUM_SAMPLES = 256,
  parameter int ACC_W       = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  approx_mult_err_accum_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           sample_cnt,
  output logic [15:0]           err_cnt,
  output logic [2*N-1:0]        max_ed,
  output logic [ACC_W-1:0]      sum_ed
`ifdef ERR_SQ_EN
  ,
  output logic [ACC_W+2*N-1:0]  sum_sq_ed
`endif
);

  localparam int          PW    = 2 * N;
  localparam logic [15:0] NUM_S = 16'(NUM_SAMPLES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic          in_ready_c;
  logic          accept;
  logic          start_take;
  logic          full;

  logic          vld_p1;
  logic [PW-1:0] exact_p1;
  logic [PW-1:0] approx_p1;
  logic          vld_p2;
  logic [PW-1:0] ed_p1;

  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  assign full       = (sample_cnt == NUM_S);
  assign start_take = start && ((state == IDLE) || (state == DONE));
  assign accept     = bus.in_valid && in_ready_c;
  assign bus.in_ready = in_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN waits until stage 1 is empty and the last stage-2 update has been
  // committed for one cycle (vld_p2), giving a fixed two-cycle drain.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (full) state_nxt = DRAIN;
      DRAIN:   if (!vld_p1 && !vld_p2) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN) || (state == DRAIN);
    done       = (state == DONE);
    in_ready_c = (state == RUN) && !full;
  end

  // Stage 1: capture exact product and approximate product on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      exact_p1   <= '0;
      approx_p1  <= '0;
      sample_cnt <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        exact_p1  <= PW'(bus.a) * PW'(bus.b);
        approx_p1 <= bus.approx_product;
      end
      if (start_take) begin
        sample_cnt <= '0;
      end else if (accept) begin
        sample_cnt <= sample_cnt + 16'd1;
      end
    end
  end

  assign ed_p1 = abs_diff(exact_p1, approx_p1);

  // Stage 2: fold ED into the run metrics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      err_cnt <= '0;
      max_ed  <= '0;
      sum_ed  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (start_take) begin
        err_cnt <= '0;
        max_ed  <= '0;
        sum_ed  <= '0;
      end else if (vld_p1) begin
        err_cnt <= err_cnt + 16'(ed_p1 != '0);
        if (ed_p1 > max_ed) max_ed <= ed_p1;
        sum_ed  <= sum_ed + ACC_W'(ed_p1);
      end
    end
  end

`ifdef ERR_SQ_EN
  logic [2*PW-1:0] ed_sq_p1;

  assign ed_sq_p1 = (2*PW)'(ed_p1) * (2*PW)'(ed_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_sq_ed <= '0;
    end else if (start_take) begin
      sum_sq_ed <= '0;
    end else if (vld_p1) begin
      sum_sq_ed <= sum_sq_ed + (ACC_W+2*N)'(ed_sq_p1);
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_err_accum.sv
module tb_approx_mult_err_accum;

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] err;
    logic [31:0] mx;
    logic [47:0] sum;
    logic [79:0] sq;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic busy0, done0, busy1, done1;
  logic [15:0] cnt0, err0, cnt1, err1;
  logic [31:0] max0, max1;
  logic [47:0] sum0, sum1;
`ifdef ERR_SQ_EN
  logic [79:0] sq0, sq1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;
  logic done0_q = 1'b0;
  logic done1_q = 1'b0;

  logic [15:0] m_cnt, m_err;
  logic [31:0] m_max;
  logic [47:0] m_sum;
  logic [79:0] m_sq;

  always #5 clk = ~clk;

  approx_mult_err_accum_if #(.N(16)) bus0 ();
  approx_mult_err_accum_if #(.N(16)) bus1 ();

  approx_mult_err_accum #(.N(16), .NUM_SAMPLES(4), .ACC_W(48)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .sample_cnt(cnt0), .err_cnt(err0),
    .max_ed(max0), .sum_ed(sum0)
`ifdef ERR_SQ_EN
    , .sum_sq_ed(sq0)
`endif
  );

  approx_mult_err_accum #(.N(16), .NUM_SAMPLES(65535), .ACC_W(48)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .sample_cnt(cnt1), .err_cnt(err1),
    .max_ed(max1), .sum_ed(sum1)
`ifdef ERR_SQ_EN
    , .sum_sq_ed(sq1)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_cnt = '0; m_err = '0; m_max = '0; m_sum = '0; m_sq = '0;
  endtask

  task automatic model_add(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ap);
    longint ex, d;
    ex = longint'(a) * longint'(b);
    d  = ex - longint'(ap);
    if (d < 0) d = -d;
    m_cnt++;
    if (d != 0) m_err++;
    if (d > longint'(m_max)) m_max = 32'(d);
    m_sum = m_sum + 48'(d);
    m_sq  = m_sq + 80'(d) * 80'(d);
  endtask

  task automatic push_expected(input int which);
    exp_t e;
    e.cnt = m_cnt; e.err = m_err; e.mx = m_max; e.sum = m_sum; e.sq = m_sq;
    if (which == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic compare_run(input string who, input exp_t e, input logic [15:0] cnt,
                             input logic [15:0] err, input logic [31:0] mx, input logic [47:0] sm);
    chk({who, "_sample_cnt"}, cnt, e.cnt);
    chk({who, "_err_cnt"}, err, e.err);
    chk({who, "_max_ed"}, mx, e.mx);
    chk({who, "_sum_ed"}, sm, e.sum);
  endtask

  // Scoreboard: one expected result set per run, popped when done rises.
  always @(negedge clk) begin
    if (done0 && !done0_q) begin
      chk("sb0_pop", sb0.size(), 1);
      if (sb0.size() > 0) begin
        e0 = sb0.pop_front();
        compare_run("run0", e0, cnt0, err0, max0, sum0);
`ifdef ERR_SQ_EN
        chk("run0_sum_sq_ed", sq0, e0.sq);
`endif
      end
    end
    done0_q = done0;
  end

  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      chk("sb1_pop", sb1.size(), 1);
      if (sb1.size() > 0) begin
        e1 = sb1.pop_front();
        compare_run("run1", e1, cnt1, err1, max1, sum1);
`ifdef ERR_SQ_EN
        chk("run1_sum_sq_ed", sq1, e1.sq);
`endif
      end
    end
    done1_q = done1;
  end

  task automatic start_run0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    model_clear();
  endtask

  task automatic drive_sample(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ap);
    bus0.in_valid = 1'b1;
    bus0.a = a;
    bus0.b = b;
    bus0.approx_product = ap;
    chk("in_ready_on_drive", bus0.in_ready, 1'b1);
    model_add(a, b, ap);
    tick();
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int which, input int bound, input string tag);
    int n = 0;
    while (!((which == 0) ? done0 : done1) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, (which == 0) ? done0 : done1, 1'b1);
    @(negedge clk);
    #1;
    chk({tag, "_sb_drained"}, (which == 0) ? sb0.size() : sb1.size(), 0);
  endtask

  function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  initial begin
    logic [15:0] ta, tb;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.approx_product = '0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.approx_product = '0;
    model_clear();
    #12;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_in_ready", bus0.in_ready, 1'b0);
    chk("rst_sample_cnt", cnt0, 16'd0);
    chk("rst_sum_ed", sum0, 48'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Test 1: reset mid-run after 2 accepts
    start_run0();
    drive_sample(16'h0010, 16'h0010, 32'h0000_0000);
    drive_sample(16'h0003, 16'h0003, 32'h0000_0009);
    tick();
    chk("t1_pre_cnt", cnt0, 16'd2);
    chk("t1_pre_sum", sum0, 48'h100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_sample_cnt", cnt0, 16'd0);
    chk("t1_err_cnt", err0, 16'd0);
    chk("t1_max_ed", max0, 32'd0);
    chk("t1_sum_ed", sum0, 48'd0);
    chk("t1_busy", busy0, 1'b0);
    chk("t1_done", done0, 1'b0);
    chk("t1_in_ready", bus0.in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("t1_idle_in_ready", bus0.in_ready, 1'b0);

    // Test 2: all exact
    start_run0();
    drive_sample(16'hFFFF, 16'hFFFF, prod(16'hFFFF, 16'hFFFF));
    drive_sample(16'h0000, 16'h1234, 32'h0);
    drive_sample(16'h0001, 16'h0001, 32'h1);
    drive_sample(16'h8000, 16'h0002, prod(16'h8000, 16'h0002));
    push_expected(0);
    wait_done(0, 10, "t2_done");

    // Test 3: two erroneous samples (ED 16 below, ED 5 above)
    start_run0();
    drive_sample(16'hFFFF, 16'h8888, 32'h8887_7778 - 32'h10);
    chk("t3_lat_sum0", sum0, 48'd0);
    drive_sample(16'hFFFF, 16'h89FF, prod(16'hFFFF, 16'h89FF) + 32'd5);
    chk("t3_lat_sum1", sum0, 48'd16);
    drive_sample(16'h1234, 16'h5678, prod(16'h1234, 16'h5678));
    drive_sample(16'h0003, 16'h0004, 32'd12);
    chk("t3_model_sum", m_sum, 48'd21);
    chk("t3_model_sq", m_sq, 80'd281);
    push_expected(0);
    wait_done(0, 10, "t3_done");

    // Test 4: in_valid held 6 cycles from RUN entry
    start_run0();
    for (int i = 0; i < 6; i++) begin
      ta = 16'(16'h0101 * (i + 1));
      tb = 16'(16'h00F3 + i * 7);
      bus0.in_valid = 1'b1;
      bus0.a = ta;
      bus0.b = tb;
      bus0.approx_product = prod(ta, tb) ^ 32'(i);
      chk($sformatf("t4_in_ready_%0d", i), bus0.in_ready, (i < 4) ? 1'b1 : 1'b0);
      if (i < 4) model_add(ta, tb, prod(ta, tb) ^ 32'(i));
      tick();
    end
    bus0.in_valid = 1'b0;
    chk("t4_cnt_capped", cnt0, 16'd4);
    chk("t4_done_early", done0, 1'b0);
    push_expected(0);
    tick();
    chk("t4_done_latency", done0, 1'b1);
    @(negedge clk);
    #1;
    chk("t4_sb_drained", sb0.size(), 0);

    // Test 5: start ignored in RUN and DRAIN
    start_run0();
    drive_sample(16'h00FF, 16'h00FF, prod(16'h00FF, 16'h00FF) - 32'd100);
    drive_sample(16'h7FFF, 16'h0003, prod(16'h7FFF, 16'h0003) + 32'd1);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("t5_run_cnt", cnt0, 16'd2);
    chk("t5_run_busy", busy0, 1'b1);
    drive_sample(16'hABCD, 16'h0010, prod(16'hABCD, 16'h0010));
    drive_sample(16'h0002, 16'h0002, 32'd1000);
    start0 = 1'b1;
    tick();
    tick();
    start0 = 1'b0;
    chk("t5_drain_busy", busy0, 1'b1);
    chk("t5_drain_cnt", cnt0, 16'd4);
    push_expected(0);
    wait_done(0, 10, "t5_done");

    // Test 6: 65535 samples, maximal ED every sample
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    model_clear();
    for (int i = 0; i < 65535; i++) model_add(16'hFFFF, 16'hFFFF, 32'd0);
    push_expected(1);
    bus1.in_valid = 1'b1;
    bus1.a = 16'hFFFF;
    bus1.b = 16'hFFFF;
    bus1.approx_product = 32'd0;
    repeat (65537) tick();
    bus1.in_valid = 1'b0;
    wait_done(1, 20, "t6_done");
    chk("t6_max_ed", max1, 32'hFFFE_0001);
    chk("t6_sum_ed", sum1, 48'(65535) * 48'hFFFE_0001);
    chk("t6_err_cnt", err1, 16'd65535);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
